// File: rtl/key_event_decoder_if.sv
// Key gesture bus: debounced press pulse and raw key level in, gesture pulses and busy out.
interface key_event_decoder_if;
    logic key_press;
    logic key_in;
    logic single_click;
    logic double_click;
    logic long_press;
    logic busy;

    modport master (
        output key_press, key_in,
        input  single_click, double_click, long_press, busy
    );

    modport slave (
        input  key_press, key_in,
        output single_click, double_click, long_press, busy
    );
endinterface

// File: rtl/key_event_decoder.sv
// Classifies debounced key gestures into single click, double click and long press pulses.
module key_event_decoder #(
    parameter int LONG_TIME  = 20000,
    parameter int DCLICK_WIN = 10000,
    parameter int REL_NUM    = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    key_event_decoder_if.slave io_key
);

    localparam logic [15:0] LONG_LAST = 16'(LONG_TIME - 1);
    localparam logic [15:0] GAP_LAST  = 16'(DCLICK_WIN - 1);
    localparam logic [15:0] REL_MAX   = 16'(REL_NUM);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        LONG   = 3'd2,
        GAP    = 3'd3,
        PRESS2 = 3'd4
    } state_t;

    typedef struct packed {
        logic single;
        logic dbl;
        logic lng;
    } evt_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_sync;
    logic [15:0] r_rel_cnt;
    logic [15:0] r_tcnt;
    evt_t        r_evt;
    evt_t        w_evt_nxt;
    logic        r_busy;
    logic        w_key_s;
    logic        w_released;
    logic        w_long_to;
    logic        w_gap_to;

    // Synchronizer idles high so a reset never looks like a held key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= 2'b11;
        else        r_sync <= {r_sync[0], io_key.key_in};
    end

    assign w_key_s = r_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_rel_cnt <= '0;
        else if (!w_key_s)         r_rel_cnt <= '0;
        else if (r_rel_cnt != REL_MAX) r_rel_cnt <= r_rel_cnt + 16'd1;
    end

    assign w_released = (r_rel_cnt == REL_MAX);
    assign w_long_to  = (r_tcnt == LONG_LAST);
    assign w_gap_to   = (r_tcnt == GAP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Release beats long timeout; a second press beats gap timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (io_key.key_press) w_next = PRESS1;
            PRESS1: begin
                if (w_released)     w_next = GAP;
                else if (w_long_to) w_next = LONG;
            end
            LONG:    if (w_released) w_next = IDLE;
            GAP: begin
                if (io_key.key_press) w_next = PRESS2;
                else if (w_gap_to)    w_next = IDLE;
            end
            PRESS2:  if (w_released) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_evt_nxt        = '0;
        w_evt_nxt.lng    = (r_state == PRESS1) && !w_released && w_long_to;
        w_evt_nxt.dbl    = (r_state == GAP) && io_key.key_press;
        w_evt_nxt.single = (r_state == GAP) && !io_key.key_press && w_gap_to;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_tcnt <= '0;
        else if (w_next != r_state)  r_tcnt <= '0;
        else if (r_state == PRESS1 || r_state == GAP) r_tcnt <= r_tcnt + 16'd1;
        else                         r_tcnt <= '0;
    end

    // Pulses and busy are registered from the next-state decode so they line up with the state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_evt  <= w_evt_nxt;
            r_busy <= (w_next != IDLE);
        end
    end

    assign io_key.single_click = r_evt.single;
    assign io_key.double_click = r_evt.dbl;
    assign io_key.long_press   = r_evt.lng;
    assign io_key.busy         = r_busy;

endmodule
